calendar_date_counter: RTL

Registered Gregorian calendar date counter (year/month/day) that advances or retreats one day per tick, with full leap-year rule (div-4, not div-100 unless div-400). Successor to the combinational month-length lookup: parametrised year width and reset date, bidirectional counting, validated load and rollover event flags. Sits below the time-of-day block; its day-carry pulse drives `tick`.

---
 rtl/calendar_date_counter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/calendar_date_counter.sv
// Gregorian calendar date counter (year/month/day).
// Steps one day forward or backward per tick, accepts validated loads and
// emits registered one-cycle roll/wrap/error pulses.
module calendar_date_counter #(
  parameter int YEAR_W      = 12,
  parameter int RESET_YEAR  = 2000,
  parameter int RESET_MONTH = 1,
  parameter int RESET_DAY   = 1,
  parameter int DOWN_EN     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              dir,
  input  logic              load,
  input  logic [YEAR_W-1:0] ld_year,
  input  logic [3:0]        ld_month,
  input  logic [4:0]        ld_day,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic              leap_year,
  output logic [4:0]        month_len,
  output logic              month_roll,
  output logic              year_roll,
  output logic              year_wrap,
  output logic              load_err
);

  localparam logic [YEAR_W-1:0] YEAR_MAX = '1;

  // Full Gregorian leap rule; year 0 counts as leap.
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] yy;
    yy = 32'(y);
    return ((yy % 32'd4 == 32'd0) && (yy % 32'd100 != 32'd0)) || (yy % 32'd400 == 32'd0);
  endfunction

  // Month length; an out-of-range month reports 31 so the counter stays bounded.
  function automatic logic [4:0] len_of(input logic [3:0] m, input logic lp);
    logic [4:0] len;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = lp ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  logic [YEAR_W-1:0] year_nxt;
  logic [3:0]        month_nxt;
  logic [4:0]        day_nxt;
  logic              month_roll_nxt;
  logic              year_roll_nxt;
  logic              year_wrap_nxt;
  logic              load_err_nxt;
  logic              step_down;
  logic              ld_ok;
  logic              month_bad;

  assign leap_year = is_leap(year);
  assign month_len = len_of(month, leap_year);
  assign step_down = (DOWN_EN != 0) && dir;
  assign month_bad = (month == 4'd0) || (month > 4'd12);
  assign ld_ok     = (ld_month >= 4'd1) && (ld_month <= 4'd12) && (ld_day >= 5'd1) &&
                     (ld_day <= len_of(ld_month, is_leap(ld_year)));

  // Next-date and pulse computation: load beats tick, pulses default low.
  always_comb begin
    year_nxt       = year;
    month_nxt      = month;
    day_nxt        = day;
    month_roll_nxt = 1'b0;
    year_roll_nxt  = 1'b0;
    year_wrap_nxt  = 1'b0;
    load_err_nxt   = 1'b0;
    if (load) begin
      if (ld_ok) begin
        year_nxt  = ld_year;
        month_nxt = ld_month;
        day_nxt   = ld_day;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (tick) begin
      if (!step_down) begin
        if (month_bad) begin
          month_nxt = 4'd1;
          day_nxt   = 5'd1;
        end else if (day < month_len) begin
          day_nxt = day + 5'd1;
        end else begin
          day_nxt        = 5'd1;
          month_roll_nxt = 1'b1;
          if (month < 4'd12) begin
            month_nxt = month + 4'd1;
          end else begin
            month_nxt     = 4'd1;
            year_roll_nxt = 1'b1;
            year_nxt      = year + 1'b1;
            year_wrap_nxt = (year == YEAR_MAX);
          end
        end
      end else begin
        if (day > 5'd1) begin
          day_nxt = day - 5'd1;
        end else begin
          month_roll_nxt = 1'b1;
          if (month > 4'd1) begin
            month_nxt = month - 4'd1;
            day_nxt   = len_of(month - 4'd1, leap_year);
          end else begin
            month_nxt     = 4'd12;
            day_nxt       = 5'd31;
            year_roll_nxt = 1'b1;
            year_nxt      = year - 1'b1;
            year_wrap_nxt = (year == '0);
          end
        end
      end
    end
  end

  // Date and pulse registers with asynchronous reset to the configured date.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      year       <= YEAR_W'(RESET_YEAR);
      month      <= 4'(RESET_MONTH);
      day        <= 5'(RESET_DAY);
      month_roll <= 1'b0;
      year_roll  <= 1'b0;
      year_wrap  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      year       <= year_nxt;
      month      <= month_nxt;
      day        <= day_nxt;
      month_roll <= month_roll_nxt;
      year_roll  <= year_roll_nxt;
      year_wrap  <= year_wrap_nxt;
      load_err   <= load_err_nxt;
    end
  end

endmodule
